// File: rtl/uart_tx_frame.sv
// uart_tx_frame: one-bit-per-clock UART framer (start, LSB-first data, optional parity, stop); P_DATA/DATA_VALID/PAR_EN/PAR_TYP in, registered TX_OUT/busy out, rst active-low sync
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);
  localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                  tx_q, tx_d, busy_q, busy_d, accept;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end
  always_comb begin
    accept    = DATA_VALID && (state_q == IDLE || state_q == STOP);
    data_d    = accept ? P_DATA : data_q;
    par_en_d  = accept ? PAR_EN : par_en_q;
    par_typ_d = accept ? PAR_TYP : par_typ_q;
    cnt_d     = state_q == DATA ? cnt_q + CW'(1) : '0;
    state_d   = state_q;
    case (state_q)
      IDLE:    state_d = accept ? START : IDLE;
      START:   state_d = DATA;
      DATA:    state_d = cnt_q == CW'(DATA_WIDTH - 1) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  state_d = STOP;
      STOP:    state_d = accept ? START : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    tx_d   = state_d == START  ? 1'b0 :
             state_d == DATA   ? data_q[cnt_d] :
             state_d == PARITY ? ^data_q ^ par_typ_q : 1'b1;
    busy_d = state_d != IDLE;
  end
  assign TX_OUT = tx_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: table vectors, directed corner sequences and random traffic against a frame-queue model
module tb_uart_tx_frame;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT, busy;
  int         tests = 0;
  int         fails = 0;
  logic [1:0] q[$];
  typedef struct {
    logic       r;
    logic       dv;
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       tx;
    logic       bz;
  } vec_t;
  vec_t tbl[$];
  uart_tx_frame #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got tx=%b busy=%b, expected tx=%b busy=%b", name, $time, act[1], act[0], exp[1], exp[0]);
    end
  endtask
  function automatic void push_frame(input logic [7:0] d, input logic pe, input logic pt);
    q.push_back(2'b01);
    for (int i = 0; i < 8; i++) q.push_back({d[i], 1'b1});
    if (pe) q.push_back({^d ^ pt, 1'b1});
    q.push_back(2'b11);
  endfunction
  task automatic step(input logic r, input logic dv, input logic [7:0] d, input logic pe, input logic pt);
    logic [1:0] e;
    rst = r; DATA_VALID = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    e = 2'b10;
    if (!r) q.delete();
    else begin
      if (q.size() == 0 && dv) push_frame(d, pe, pt);
      if (q.size() != 0) e = q.pop_front();
    end
    @(posedge clk);
    #1;
    check("model", {TX_OUT, busy}, e);
  endtask
  task automatic add(input logic r, input logic dv, input logic [7:0] d, input logic pe, input logic pt, input logic tx, input logic bz);
    vec_t v;
    v.r = r; v.dv = dv; v.d = d; v.pe = pe; v.pt = pt; v.tx = tx; v.bz = bz;
    tbl.push_back(v);
  endtask
  task automatic add_frame(input logic [7:0] d, input logic pe, input logic pt, input logic par);
    add(1, 1, d, pe, pt, 0, 1);
    for (int i = 0; i < 8; i++) add(1, 0, d, pe, pt, d[i], 1);
    if (pe) add(1, 0, d, pe, pt, par, 1);
    add(1, 0, d, pe, pt, 1, 1);
    add(1, 0, d, pe, pt, 1, 0);
  endtask
  initial begin
    add(0, 1, 8'hA5, 0, 0, 1, 0);
    add(0, 1, 8'hA5, 0, 0, 1, 0);
    add(1, 0, 8'hA5, 0, 0, 1, 0);
    add_frame(8'hA5, 0, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 0);
    add_frame(8'hA5, 1, 0, 0);
    add_frame(8'hA5, 1, 1, 1);
    add_frame(8'h07, 1, 0, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].dv, tbl[i].d, tbl[i].pe, tbl[i].pt);
      check("table", {TX_OUT, busy}, {tbl[i].tx, tbl[i].bz});
    end
    step(1, 1, 8'h3C, 0, 0);
    step(1, 0, 8'hFF, 1, 0);
    step(1, 1, 8'hFF, 1, 1);
    repeat (7) step(1, 0, 8'hFF, 1, 1);
    check("midframe_stop", {TX_OUT, busy}, 2'b11);
    step(1, 0, 8'hFF, 1, 1);
    check("midframe_end", {TX_OUT, busy}, 2'b10);
    step(1, 1, 8'hA5, 0, 0);
    repeat (9) step(1, 0, 8'hA5, 0, 0);
    check("b2b_stop", {TX_OUT, busy}, 2'b11);
    step(1, 1, 8'h55, 0, 0);
    check("b2b_start", {TX_OUT, busy}, 2'b01);
    step(1, 0, 8'h00, 0, 0);
    check("b2b_bit0", {TX_OUT, busy}, 2'b11);
    repeat (9) step(1, 0, 8'h00, 0, 0);
    check("b2b_end", {TX_OUT, busy}, 2'b10);
    step(1, 1, 8'hF0, 0, 0);
    repeat (5) step(1, 0, 8'hF0, 0, 0);
    check("rst_bit4", {TX_OUT, busy}, 2'b11);
    step(0, 1, 8'h0F, 1, 1);
    check("rst_mid", {TX_OUT, busy}, 2'b10);
    step(1, 1, 8'hF0, 1, 1);
    check("rst_restart", {TX_OUT, busy}, 2'b01);
    repeat (10) step(1, 0, 8'h00, 0, 0);
    check("rst_stop", {TX_OUT, busy}, 2'b11);
    step(1, 0, 8'h00, 0, 0);
    check("rst_end", {TX_OUT, busy}, 2'b10);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 3) == 0, 8'($urandom),
           1'($urandom), 1'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
